// File: rtl/fft_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback FFT stage with a D-entry complex feedback line.
// Optional build macro FFT_SCALE_EN: halve sum and product (round-half-up) before saturation.
module fft_sdf_stage #(
    parameter int DW    = 12,
    parameter int TW    = 12,
    parameter int LOG2D = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic signed [DW-1:0] in_r,
    input  logic signed [DW-1:0] in_i,
    output logic [LOG2D-1:0]     tw_idx,
    input  logic signed [TW-1:0] tw_r,
    input  logic signed [TW-1:0] tw_i,
    output logic                 out_valid,
    output logic                 out_sop,
    output logic signed [DW-1:0] out_r,
    output logic signed [DW-1:0] out_i,
    output logic                 sat_flag,
    output logic                 sync_err
);

    localparam int D  = 1 << LOG2D;
    localparam int CW = LOG2D + 1;
    localparam int SW = DW + 1;
    localparam int PW = SW + TW + 1;
    localparam logic [CW-1:0] CNT_D   = CW'(D);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    function automatic logic signed [PW-1:0] round_prod(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] half;
        logic signed [PW-1:0] rnd;
        half = '0;
        half[TW-3] = 1'b1;
        rnd = p + half;
        return rnd >>> (TW - 2);
    endfunction

    function automatic logic signed [PW-1:0] scale_half(input logic signed [PW-1:0] x);
`ifdef FFT_SCALE_EN
        logic signed [PW-1:0] one;
        logic signed [PW-1:0] t;
        one = 1;
        t = x + one;
        return t >>> 1;
`else
        return x;
`endif
    endfunction

    // Returns {clipped, value}; clipped is set when x lies outside the DW-bit signed range.
    function automatic logic [DW:0] saturate(input logic signed [PW-1:0] x);
        logic signed [PW-1:0] hi;
        logic signed [PW-1:0] lo;
        hi = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
        lo = ~hi;
        if (x > hi) begin
            return {1'b1, hi[DW-1:0]};
        end else if (x < lo) begin
            return {1'b1, lo[DW-1:0]};
        end else begin
            return {1'b0, x[DW-1:0]};
        end
    endfunction

    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 primed_q, primed_d;
    logic signed [DW-1:0] dl_r_q [D];
    logic signed [DW-1:0] dl_i_q [D];
    logic signed [DW-1:0] dl_r_d [D];
    logic signed [DW-1:0] dl_i_d [D];
    logic signed [DW-1:0] out_r_p1_q, out_r_p1_d;
    logic signed [DW-1:0] out_i_p1_q, out_i_p1_d;
    logic                 vld_p1_q, vld_p1_d;
    logic                 sop_p1_q, sop_p1_d;
    logic                 sat_q, sat_d;
    logic                 sync_err_q, sync_err_d;

    logic signed [DW-1:0] head_r, head_i;
    logic signed [SW-1:0] sum_r, sum_i, dif_r, dif_i;
    logic signed [PW-1:0] sum_r_x, sum_i_x;
    logic signed [PW-1:0] dr_x, di_x, wr_x, wi_x;
    logic signed [PW-1:0] prod_r, prod_i;
    logic [DW:0]          sr_s, si_s, pr_s, pi_s;
    logic                 resync, bfly;

    // Stage p0: butterfly arithmetic on the delay-line head and the incoming sample
    assign head_r = dl_r_q[D-1];
    assign head_i = dl_i_q[D-1];

    assign sum_r = {head_r[DW-1], head_r} + {in_r[DW-1], in_r};
    assign sum_i = {head_i[DW-1], head_i} + {in_i[DW-1], in_i};
    assign dif_r = {head_r[DW-1], head_r} - {in_r[DW-1], in_r};
    assign dif_i = {head_i[DW-1], head_i} - {in_i[DW-1], in_i};

    assign sum_r_x = {{(PW-SW){sum_r[SW-1]}}, sum_r};
    assign sum_i_x = {{(PW-SW){sum_i[SW-1]}}, sum_i};
    assign dr_x    = {{(PW-SW){dif_r[SW-1]}}, dif_r};
    assign di_x    = {{(PW-SW){dif_i[SW-1]}}, dif_i};
    assign wr_x    = {{(PW-TW){tw_r[TW-1]}}, tw_r};
    assign wi_x    = {{(PW-TW){tw_i[TW-1]}}, tw_i};

    assign prod_r = dr_x * wr_x - di_x * wi_x;
    assign prod_i = dr_x * wi_x + di_x * wr_x;

    assign sr_s = saturate(scale_half(sum_r_x));
    assign si_s = saturate(scale_half(sum_i_x));
    assign pr_s = saturate(scale_half(round_prod(prod_r)));
    assign pi_s = saturate(scale_half(round_prod(prod_i)));

    // A mid-frame start restarts the frame: the sample becomes fill index 0.
    assign resync = in_sop && (cnt_q != '0);
    assign bfly   = cnt_q[LOG2D] && !resync;
    assign tw_idx = cnt_q[LOG2D] ? cnt_q[LOG2D-1:0] : '0;

    always_comb begin
        cnt_d      = cnt_q;
        primed_d   = primed_q;
        dl_r_d     = dl_r_q;
        dl_i_d     = dl_i_q;
        out_r_p1_d = out_r_p1_q;
        out_i_p1_d = out_i_p1_q;
        vld_p1_d   = 1'b0;
        sop_p1_d   = 1'b0;
        sat_d      = sat_q;
        sync_err_d = 1'b0;
        if (in_valid) begin
            for (int k = D - 1; k > 0; k--) begin
                dl_r_d[k] = dl_r_q[k-1];
                dl_i_d[k] = dl_i_q[k-1];
            end
            if (bfly) begin
                dl_r_d[0]  = pr_s[DW-1:0];
                dl_i_d[0]  = pi_s[DW-1:0];
                out_r_p1_d = sr_s[DW-1:0];
                out_i_p1_d = si_s[DW-1:0];
                sat_d      = sat_q | sr_s[DW] | si_s[DW] | pr_s[DW] | pi_s[DW];
            end else begin
                dl_r_d[0]  = in_r;
                dl_i_d[0]  = in_i;
                out_r_p1_d = head_r;
                out_i_p1_d = head_i;
            end
            if (resync) begin
                cnt_d      = CNT_ONE;
                primed_d   = 1'b0;
                sync_err_d = 1'b1;
            end else begin
                cnt_d    = cnt_q + CNT_ONE;
                primed_d = primed_q | (cnt_q == CNT_D);
                sop_p1_d = (cnt_q == CNT_D);
            end
            vld_p1_d = primed_d;
        end
    end

    // Stage p1: registered output and control state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            primed_q   <= 1'b0;
            out_r_p1_q <= '0;
            out_i_p1_q <= '0;
            vld_p1_q   <= 1'b0;
            sop_p1_q   <= 1'b0;
            sat_q      <= 1'b0;
            sync_err_q <= 1'b0;
            for (int k = 0; k < D; k++) begin
                dl_r_q[k] <= '0;
                dl_i_q[k] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            primed_q   <= primed_d;
            out_r_p1_q <= out_r_p1_d;
            out_i_p1_q <= out_i_p1_d;
            vld_p1_q   <= vld_p1_d;
            sop_p1_q   <= sop_p1_d;
            sat_q      <= sat_d;
            sync_err_q <= sync_err_d;
            dl_r_q     <= dl_r_d;
            dl_i_q     <= dl_i_d;
        end
    end

    assign out_r     = out_r_p1_q;
    assign out_i     = out_i_p1_q;
    assign out_valid = vld_p1_q;
    assign out_sop   = sop_p1_q;
    assign sat_flag  = sat_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Directed bench for fft_sdf_stage at DW=12, TW=12, LOG2D=2 with an 8-point twiddle ROM.
module tb_fft_sdf_stage;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_sop;
    logic signed [11:0]  in_r;
    logic signed [11:0]  in_i;
    logic [1:0]          tw_idx;
    logic signed [11:0]  tw_r;
    logic signed [11:0]  tw_i;
    logic                out_valid;
    logic                out_sop;
    logic signed [11:0]  out_r;
    logic signed [11:0]  out_i;
    logic                sat_flag;
    logic                sync_err;

    localparam logic signed [11:0] ROM_R [4] = '{12'sd1024, 12'sd724, 12'sd0, -12'sd724};
    localparam logic signed [11:0] ROM_I [4] = '{12'sd0, -12'sd724, -12'sd1024, -12'sd724};

    assign tw_r = ROM_R[tw_idx];
    assign tw_i = ROM_I[tw_idx];

    fft_sdf_stage #(.DW(12), .TW(12), .LOG2D(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_sop   (in_sop),
        .in_r     (in_r),
        .in_i     (in_i),
        .tw_idx   (tw_idx),
        .tw_r     (tw_r),
        .tw_i     (tw_i),
        .out_valid(out_valid),
        .out_sop  (out_sop),
        .out_r    (out_r),
        .out_i    (out_i),
        .sat_flag (sat_flag),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    int    xr [8];
    int    xi [8];
    int    er [8];
    int    ei [8];
    string scn;

    function automatic int sc(input int v);
`ifdef FFT_SCALE_EN
        return (v + 1) >>> 1;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit s, input int r, input int i);
        @(negedge clk);
        in_valid = v;
        in_sop   = s;
        in_r     = 12'(r);
        in_i     = 12'(i);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_r     = '0;
        in_i     = '0;
        tick();
        tick();
        chk({tag, " rst out_valid"}, out_valid, 0);
        chk({tag, " rst out_sop"}, out_sop, 0);
        chk({tag, " rst out_r"}, out_r, 0);
        chk({tag, " rst out_i"}, out_i, 0);
        chk({tag, " rst sat_flag"}, sat_flag, 0);
        chk({tag, " rst sync_err"}, sync_err, 0);
        chk({tag, " rst tw_idx"}, tw_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Feeds frame xr/xi then a zero frame, checking out[0..3] during the frame and out[4..7] during the flush.
    task automatic run_frame(input bit stall, input bit sop_first, input bit exp_sync);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, sop_first && (k == 0), xr[k], xi[k]);
            #1;
            chk($sformatf("%s tw_idx s%0d", scn, k), tw_idx, (k >= 4) ? k - 4 : 0);
            tick();
            chk($sformatf("%s sync_err s%0d", scn, k), sync_err, (exp_sync && k == 0) ? 1 : 0);
            if (k < 4) begin
                chk($sformatf("%s out_valid s%0d", scn, k), out_valid, 0);
            end else begin
                chk($sformatf("%s out_valid s%0d", scn, k), out_valid, 1);
                chk($sformatf("%s out_sop s%0d", scn, k), out_sop, (k == 4) ? 1 : 0);
                chk($sformatf("%s out_r[%0d]", scn, k - 4), out_r, er[k-4]);
                chk($sformatf("%s out_i[%0d]", scn, k - 4), out_i, ei[k-4]);
            end
            if (stall) begin
                drive(1'b0, 1'b0, 0, 0);
                tick();
                chk($sformatf("%s stall out_valid s%0d", scn, k), out_valid, 0);
                chk($sformatf("%s stall out_sop s%0d", scn, k), out_sop, 0);
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, k == 0, 0, 0);
            tick();
            chk($sformatf("%s flush out_valid z%0d", scn, k), out_valid, 1);
            chk($sformatf("%s flush out_sop z%0d", scn, k), out_sop, 0);
            chk($sformatf("%s out_r[%0d]", scn, k + 4), out_r, er[k+4]);
            chk($sformatf("%s out_i[%0d]", scn, k + 4), out_i, ei[k+4]);
            if (stall) begin
                drive(1'b0, 1'b0, 0, 0);
                tick();
                chk($sformatf("%s flush stall out_valid z%0d", scn, k), out_valid, 0);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_r     = '0;
        in_i     = '0;

        // Impulse at sample 0
        do_reset("impulse");
        scn = "impulse";
        xr = '{100, 0, 0, 0, 0, 0, 0, 0};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        er = '{sc(100), 0, 0, 0, sc(100), 0, 0, 0};
        ei = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_frame(1'b0, 1'b1, 1'b0);
        chk("impulse sat_flag", sat_flag, 0);

        // DC after a reset that interrupts a partial frame; first accept carries no in_sop
        do_reset("pre_dc");
        drive(1'b1, 1'b1, 333, -77);
        tick();
        drive(1'b1, 1'b0, 444, 55);
        tick();
        do_reset("dc");
        scn = "dc";
        xr = '{200, 200, 200, 200, 200, 200, 200, 200};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        er = '{sc(400), sc(400), sc(400), sc(400), 0, 0, 0, 0};
        ei = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_frame(1'b0, 1'b0, 1'b0);

        // Twiddle rounding: x[1] = 100 gives 100 at out[1] and 71-j71 at out[5]
        do_reset("round");
        scn = "round";
        xr = '{0, 100, 0, 0, 0, 0, 0, 0};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        er = '{0, sc(100), 0, 0, 0, sc(71), 0, 0};
        ei = '{0, 0, 0, 0, 0, sc(-71), 0, 0};
        run_frame(1'b0, 1'b1, 1'b0);
        chk("round sat_flag", sat_flag, 0);

        // Saturation on the sum of two full-scale samples
        do_reset("sat");
        scn = "sat";
        xr = '{2047, 0, 0, 0, 2047, 0, 0, 0};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        er = '{2047, 0, 0, 0, 0, 0, 0, 0};
        ei = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_frame(1'b0, 1'b1, 1'b0);
`ifdef FFT_SCALE_EN
        chk("sat sat_flag", sat_flag, 0);
`else
        chk("sat sat_flag", sat_flag, 1);
        drive(1'b1, 1'b0, 0, 0);
        tick();
        chk("sat sat_flag sticky", sat_flag, 1);
`endif

        // DC with in_valid toggling
        do_reset("stall");
        scn = "stall";
        xr = '{200, 200, 200, 200, 200, 200, 200, 200};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        er = '{sc(400), sc(400), sc(400), sc(400), 0, 0, 0, 0};
        ei = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_frame(1'b1, 1'b1, 1'b0);

        // Resync: in_sop arrives at sample index 3, then a DC frame follows from there
        do_reset("resync");
        scn = "resync";
        drive(1'b1, 1'b1, 55, 11);
        tick();
        drive(1'b1, 1'b0, 66, 22);
        tick();
        drive(1'b1, 1'b0, 77, 33);
        tick();
        chk("resync pre sync_err", sync_err, 0);
        xr = '{200, 200, 200, 200, 200, 200, 200, 200};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        er = '{sc(400), sc(400), sc(400), sc(400), 0, 0, 0, 0};
        ei = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_frame(1'b0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
